// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Default sizes and shared types for the scoreboarded register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_NUM_REGS = 4;

    typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0] reg_idx_t;
    typedef logic [DEFAULT_DATA_W-1:0]           data_word_t;

endpackage

`default_nettype wire

// File: rtl/regfile_busy_tracker.sv
// ============================================================================
// Module   : regfile_busy_tracker
// Purpose  : Per-register busy bits, outstanding-op counter, issue/wb/wr
//            legality and the registered error pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_busy_tracker #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int MAX_PEND = 2,
    parameter int R0_ZERO  = 0,
    parameter int PCNT_W   = $clog2(MAX_PEND + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                flush,
    output logic                issue_ack,
    output logic                wb_legal,
    output logic                wr_accept,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [PCNT_W-1:0]   pend_cnt,
    output logic                pend_full,
    output logic                err_pulse
);

    logic [NUM_REGS-1:0] r_busy;
    logic [PCNT_W-1:0]   r_cnt;
    logic                r_err;

    logic                w_issue_r0;
    logic                w_wb_r0;
    logic                w_wr_r0;
    logic                w_wb_legal;
    logic                w_slot_ok;
    logic                w_issue_ok;
    logic                w_ack;
    logic                w_set;
    logic                w_wb_wr_hit;
    logic                w_wr_ok;
    logic                w_err;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [PCNT_W-1:0]   w_cnt_next;

    assign w_issue_r0 = (R0_ZERO != 0) && (issue_addr == '0);
    assign w_wb_r0    = (R0_ZERO != 0) && (wb_addr == '0);
    assign w_wr_r0    = (R0_ZERO != 0) && (wr_addr == '0);

    assign w_wb_legal = wb_en & ~w_wb_r0 & r_busy[wb_addr];
    // A legal writeback frees a slot (and the target itself) in the same cycle.
    assign w_slot_ok  = (r_cnt != PCNT_W'(MAX_PEND)) | w_wb_legal;
    assign w_issue_ok = ~r_busy[issue_addr] | (w_wb_legal & (wb_addr == issue_addr));
    assign w_ack      = issue_en & ~flush & (w_issue_r0 | (w_issue_ok & w_slot_ok));
    assign w_set      = w_ack & ~w_issue_r0;

    // Writeback always wins a same-register collision with a direct write.
    assign w_wb_wr_hit = wb_en & ~w_wb_r0 & (wb_addr == wr_addr);
    assign w_wr_ok     = wr_en & ~w_wr_r0 & ~r_busy[wr_addr] & ~w_wb_wr_hit;
    assign w_err       = (wr_en & ~w_wr_r0 & ~w_wr_ok) |
                         (wb_en & ~w_wb_r0 & ~r_busy[wb_addr]);

    assign w_set_mask = w_set      ? (NUM_REGS'(1) << issue_addr) : '0;
    assign w_clr_mask = w_wb_legal ? (NUM_REGS'(1) << wb_addr)    : '0;
    assign w_cnt_next = r_cnt + PCNT_W'(w_set) - PCNT_W'(w_wb_legal);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_err;
            if (flush) begin
                r_busy <= '0;
                r_cnt  <= '0;
            end else begin
                r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
                r_cnt  <= w_cnt_next;
            end
        end
    end

    assign issue_ack = w_ack;
    assign wb_legal  = w_wb_legal;
    assign wr_accept = w_wr_ok;
    assign busy_vec  = r_busy;
    assign pend_cnt  = r_cnt;
    assign pend_full = (r_cnt == PCNT_W'(MAX_PEND));
    assign err_pulse = r_err;

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Multi-read register file with busy-bit hazard scoreboard.
//            Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to reads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int MAX_PEND = 2,
    parameter int R0_ZERO  = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0]     rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         issue_en,
    input  logic [ADDR_W-1:0]            issue_addr,
    output logic                         issue_ack,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         flush,
    output logic [NUM_REGS-1:0]          busy_vec,
    output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt,
    output logic                         pend_full,
    output logic                         err_pulse,
    output logic [NUM_REGS*DATA_W-1:0]   debug_out
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wb_legal;
    logic              w_wr_accept;

    regfile_busy_tracker #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .MAX_PEND (MAX_PEND),
        .R0_ZERO  (R0_ZERO)
    ) u_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .flush      (flush),
        .issue_ack  (issue_ack),
        .wb_legal   (w_wb_legal),
        .wr_accept  (w_wr_accept),
        .busy_vec   (busy_vec),
        .pend_cnt   (pend_cnt),
        .pend_full  (pend_full),
        .err_pulse  (err_pulse)
    );

    // Tracker guarantees wb and wr never accept the same register together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wb_legal) begin
                r_regs[wb_addr] <= wb_data;
            end
            if (w_wr_accept) begin
                r_regs[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_r0;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_r0   = (R0_ZERO != 0) && (w_addr == '0);

        always_comb begin
            w_data = w_r0 ? '0 : r_regs[w_addr];
            w_busy = w_r0 ? 1'b0 : busy_vec[w_addr];
`ifdef REGFILE_BYPASS_EN
            if (w_wb_legal && (wb_addr == w_addr)) begin
                w_data = wb_data;
                w_busy = 1'b0;
            end else if (w_wr_accept && (wr_addr == w_addr)) begin
                w_data = wr_data;
                w_busy = 1'b0;
            end
`endif
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_data;
        assign rd_busy[k]                  = w_busy;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_dbg
        assign debug_out[(NUM_REGS-1-i)*DATA_W +: DATA_W] = r_regs[i];
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Directed self-checking bench for regfile_scoreboard (default sizes).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int AW  = 2;
    localparam int NRD = 2;
    localparam int PW  = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic              issue_ack;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              flush;
    logic [NR-1:0]     busy_vec;
    logic [PW-1:0]     pend_cnt;
    logic              pend_full;
    logic              err_pulse;
    logic [NR*DW-1:0]  debug_out;

    int tests = 0;
    int fails = 0;

    regfile_scoreboard dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .issue_ack  (issue_ack),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .busy_vec   (busy_vec),
        .pend_cnt   (pend_cnt),
        .pend_full  (pend_full),
        .err_pulse  (err_pulse),
        .debug_out  (debug_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Advance past the next rising edge; inputs are changed after this returns.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        issue_en = 1'b0;
        wb_en    = 1'b0;
        flush    = 1'b0;
    endtask

    function automatic logic [DW-1:0] reg_of(input int idx);
        logic [NR*DW-1:0] d;
        d = debug_out;
        return d[(NR-1-idx)*DW +: DW];
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        issue_addr = '0; wb_addr = '0; wb_data = '0;
        #3;
        tests++; if (busy_vec !== 4'b0000 || pend_cnt !== 2'd0 || err_pulse !== 1'b0) begin
            fails++; $display("FAIL reset_state: busy=%b cnt=%0d err=%b, expected 0000/0/0", busy_vec, pend_cnt, err_pulse);
        end
        tests++; if (debug_out !== 32'h0) begin
            fails++; $display("FAIL reset_debug: got %h expected 00000000", debug_out);
        end
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h22;
        cyc(); idle();
        issue_en = 1'b1; issue_addr = 2'd1;
        cyc();
        issue_addr = 2'd2;
        cyc();
        issue_addr = 2'd3;
        tests++; if (busy_vec !== 4'b0110 || pend_cnt !== 2'd2 || debug_out !== 32'h00220000) begin
            fails++; $display("FAIL reset_pre: busy=%b cnt=%0d dbg=%h, expected 0110/2/00220000", busy_vec, pend_cnt, debug_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if (busy_vec !== 4'b0000 || pend_cnt !== 2'd0 || debug_out !== 32'h0) begin
            fails++; $display("FAIL reset_async: busy=%b cnt=%0d dbg=%h, expected 0000/0/00000000", busy_vec, pend_cnt, debug_out);
        end
        idle();
        #1;
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_raw();
        issue_en = 1'b1; issue_addr = 2'd2;
        #1;
        tests++; if (issue_ack !== 1'b1) begin
            fails++; $display("FAIL raw_ack: got %b expected 1", issue_ack);
        end
        cyc(); idle();
        rd_addr = {2'd0, 2'd2};
        #1;
        tests++; if (rd_busy[0] !== 1'b1 || pend_cnt !== 2'd1) begin
            fails++; $display("FAIL raw_busy: rd_busy=%b cnt=%0d expected 1/1", rd_busy[0], pend_cnt);
        end
        wb_en = 1'b1; wb_addr = 2'd2; wb_data = 8'hA5;
        cyc(); idle();
        tests++; if (rd_data[7:0] !== 8'hA5 || rd_busy[0] !== 1'b0 || pend_cnt !== 2'd0 || err_pulse !== 1'b0) begin
            fails++; $display("FAIL raw_wb: data=%h busy=%b cnt=%0d err=%b expected a5/0/0/0", rd_data[7:0], rd_busy[0], pend_cnt, err_pulse);
        end
    endtask

    task automatic test_limit();
        issue_en = 1'b1; issue_addr = 2'd1;
        cyc();
        issue_addr = 2'd2;
        cyc();
        issue_addr = 2'd3;
        #1;
        tests++; if (issue_ack !== 1'b0 || pend_full !== 1'b1 || pend_cnt !== 2'd2) begin
            fails++; $display("FAIL limit_full: ack=%b full=%b cnt=%0d expected 0/1/2", issue_ack, pend_full, pend_cnt);
        end
        cyc();
        tests++; if (busy_vec !== 4'b0110) begin
            fails++; $display("FAIL limit_reject: busy=%b expected 0110", busy_vec);
        end
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h5A;
        #1;
        tests++; if (issue_ack !== 1'b1) begin
            fails++; $display("FAIL limit_wb_ack: got %b expected 1", issue_ack);
        end
        cyc(); idle();
        tests++; if (pend_cnt !== 2'd2 || busy_vec !== 4'b1100 || reg_of(1) !== 8'h5A || err_pulse !== 1'b0) begin
            fails++; $display("FAIL limit_swap: cnt=%0d busy=%b r1=%h err=%b expected 2/1100/5a/0", pend_cnt, busy_vec, reg_of(1), err_pulse);
        end
        wb_en = 1'b1; wb_addr = 2'd2; wb_data = 8'h77;
        cyc();
        wb_addr = 2'd3; wb_data = 8'h33;
        cyc(); idle();
        tests++; if (pend_cnt !== 2'd0 || busy_vec !== 4'b0000) begin
            fails++; $display("FAIL limit_drain: cnt=%0d busy=%b expected 0/0000", pend_cnt, busy_vec);
        end
    endtask

    task automatic test_waw();
        issue_en = 1'b1; issue_addr = 2'd1;
        cyc(); idle();
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h11;
        cyc(); idle();
        tests++; if (err_pulse !== 1'b1 || reg_of(1) !== 8'h5A) begin
            fails++; $display("FAIL waw_drop: err=%b r1=%h expected 1/5a", err_pulse, reg_of(1));
        end
        cyc();
        tests++; if (err_pulse !== 1'b0) begin
            fails++; $display("FAIL waw_pulse_len: err=%b expected 0", err_pulse);
        end
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h61;
        cyc(); idle();
        wb_en = 1'b1; wb_addr = 2'd3; wb_data = 8'hEE;
        cyc(); idle();
        tests++; if (err_pulse !== 1'b1 || reg_of(3) !== 8'h33 || reg_of(1) !== 8'h61 || pend_cnt !== 2'd0) begin
            fails++; $display("FAIL wb_illegal: err=%b r3=%h r1=%h cnt=%0d expected 1/33/61/0", err_pulse, reg_of(3), reg_of(1), pend_cnt);
        end
        cyc();
    endtask

    task automatic test_collision();
        issue_en = 1'b1; issue_addr = 2'd2;
        cyc();
        wb_en = 1'b1; wb_addr = 2'd2; wb_data = 8'hB2;
        #1;
        tests++; if (issue_ack !== 1'b1) begin
            fails++; $display("FAIL coll_ack: got %b expected 1", issue_ack);
        end
        cyc(); idle();
        tests++; if (reg_of(2) !== 8'hB2 || busy_vec !== 4'b0100 || pend_cnt !== 2'd1 || err_pulse !== 1'b0) begin
            fails++; $display("FAIL coll_wb_issue: r2=%h busy=%b cnt=%0d err=%b expected b2/0100/1/0", reg_of(2), busy_vec, pend_cnt, err_pulse);
        end
        issue_en = 1'b1; issue_addr = 2'd1;
        cyc(); idle();
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h99;
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'hC1;
        cyc(); idle();
        tests++; if (reg_of(1) !== 8'hC1 || err_pulse !== 1'b1 || pend_cnt !== 2'd1) begin
            fails++; $display("FAIL coll_wr_wb: r1=%h err=%b cnt=%0d expected c1/1/1", reg_of(1), err_pulse, pend_cnt);
        end
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h3D;
        wb_en = 1'b1; wb_addr = 2'd2; wb_data = 8'hD2;
        cyc(); idle();
        tests++; if (reg_of(3) !== 8'h3D || reg_of(2) !== 8'hD2 || err_pulse !== 1'b0 || pend_cnt !== 2'd0) begin
            fails++; $display("FAIL coll_diff: r3=%h r2=%h err=%b cnt=%0d expected 3d/d2/0/0", reg_of(3), reg_of(2), err_pulse, pend_cnt);
        end
    endtask

    task automatic test_flush();
        issue_en = 1'b1; issue_addr = 2'd1;
        cyc();
        issue_addr = 2'd2;
        cyc();
        flush = 1'b1; issue_addr = 2'd3;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h0F;
        #1;
        tests++; if (issue_ack !== 1'b0 || pend_cnt !== 2'd2) begin
            fails++; $display("FAIL flush_ack: ack=%b cnt=%0d expected 0/2", issue_ack, pend_cnt);
        end
        cyc(); idle();
        tests++; if (busy_vec !== 4'b0000 || pend_cnt !== 2'd0 || pend_full !== 1'b0) begin
            fails++; $display("FAIL flush_state: busy=%b cnt=%0d full=%b expected 0000/0/0", busy_vec, pend_cnt, pend_full);
        end
        tests++; if (debug_out !== 32'h0FC1D23D) begin
            fails++; $display("FAIL flush_data: got %h expected 0fc1d23d", debug_out);
        end
    endtask

    task automatic test_bypass();
        issue_en = 1'b1; issue_addr = 2'd3;
        cyc(); idle();
        rd_addr = {2'd3, 2'd0};
        wb_en = 1'b1; wb_addr = 2'd3; wb_data = 8'h3C;
        #1;
`ifdef REGFILE_BYPASS_EN
        tests++; if (rd_data[15:8] !== 8'h3C || rd_busy[1] !== 1'b0) begin
            fails++; $display("FAIL bypass_same: data=%h busy=%b expected 3c/0", rd_data[15:8], rd_busy[1]);
        end
`else
        tests++; if (rd_data[15:8] !== 8'h3D || rd_busy[1] !== 1'b1) begin
            fails++; $display("FAIL nobypass_same: data=%h busy=%b expected 3d/1", rd_data[15:8], rd_busy[1]);
        end
`endif
        cyc(); idle();
        tests++; if (rd_data[15:8] !== 8'h3C || rd_busy[1] !== 1'b0 || rd_data[7:0] !== 8'h0F) begin
            fails++; $display("FAIL bypass_next: p1=%h busy=%b p0=%h expected 3c/0/0f", rd_data[15:8], rd_busy[1], rd_data[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_limit();
        test_waw();
        test_collision();
        test_flush();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
